gf180mcu_fd_sc_mcu7t5v0__idledet4_1: RTL and testbench

GF180MCU_FD_SC_MCU7T5V0__IDLEDET4_1 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__idledet4_1

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__idledet4_1.sv | 89 ++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__idledet4_1.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__idledet4_1.sv
// gf180mcu_fd_sc_mcu7t5v0__idledet4_1: synchronized NOR4 idle detector with idle counter and wake pulse
module gf180mcu_fd_sc_mcu7t5v0__idledet4_1 #(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             A1,
    input  logic             A2,
    input  logic             A3,
    input  logic             A4,
    input  logic             E,
    output logic             ZN,
    output logic             IDLE,
    output logic             WAKE,
    output logic [CNT_W-1:0] CNT
);
    typedef enum logic [1:0] {S_ACTIVE, S_COUNT, S_IDLE} state_t;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (CNT_W < 1 || IDLE_CYCLES < 1 || IDLE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_idle
        $error("IDLE_CYCLES must be 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   raw;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   wake, wake_n;

    assign raw = ~(A1 | A2 | A3 | A4);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync  <= '0;
            state <= S_ACTIVE;
            cnt   <= '0;
            wake  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw};
            state <= state_n;
            cnt   <= cnt_n;
            wake  <= wake_n;
        end
    end

    // All decisions use the synchronized ZN only, so raw glitches never bypass the chain
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wake_n  = 1'b0;
        if (!E) begin
            state_n = S_ACTIVE;
            cnt_n   = '0;
        end else begin
            case (state)
                S_ACTIVE: begin
                    state_n = ZN ? (IDLE_CYCLES == 1 ? S_IDLE : S_COUNT) : S_ACTIVE;
                    cnt_n   = ZN ? ONE : '0;
                end
                S_COUNT: begin
                    state_n = !ZN ? S_ACTIVE : (cnt == LAST ? S_IDLE : S_COUNT);
                    cnt_n   = !ZN ? '0 : (cnt == LAST ? FULL : cnt + ONE);
                end
                S_IDLE: begin
                    state_n = ZN ? S_IDLE : S_ACTIVE;
                    cnt_n   = ZN ? cnt : '0;
                    wake_n  = !ZN;
                end
                default: begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign ZN   = sync[SYNC_STAGES-1];
    assign IDLE = (state == S_IDLE);
    assign WAKE = wake;
    assign CNT  = cnt;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__idledet4_1.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__idledet4_1: directed checks of the idle detector, default and IDLE_CYCLES=1 builds
module tb_gf180mcu_fd_sc_mcu7t5v0__idledet4_1;
    logic       CLK = 1'b0;
    logic       RN  = 1'b1;
    logic       A1 = 1'b0, A2 = 1'b0, A3 = 1'b0, A4 = 1'b0;
    logic       E   = 1'b0;
    logic       ZN, IDLE, WAKE;
    logic [3:0] CNT;
    logic       ZN1, IDLE1, WAKE1;
    logic [3:0] CNT1;
    int         n_checks = 0;
    int         n_fail   = 0;

    gf180mcu_fd_sc_mcu7t5v0__idledet4_1 dut (
        .CLK(CLK), .RN(RN), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .E(E),
        .ZN(ZN), .IDLE(IDLE), .WAKE(WAKE), .CNT(CNT)
    );

    gf180mcu_fd_sc_mcu7t5v0__idledet4_1 #(.IDLE_CYCLES(1)) dut1 (
        .CLK(CLK), .RN(RN), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .E(E),
        .ZN(ZN1), .IDLE(IDLE1), .WAKE(WAKE1), .CNT(CNT1)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2 RN = 1'b0;
        #1;
        n_checks++;
        if ({ZN, IDLE, WAKE, CNT} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_async {ZN,IDLE,WAKE,CNT} got %b want 0000000", {ZN, IDLE, WAKE, CNT});
        end
        repeat (3) step();
        n_checks++;
        if ({ZN, IDLE, WAKE, CNT, ZN1, IDLE1, WAKE1, CNT1} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_held got %b/%b want all zero", {ZN, IDLE, WAKE, CNT}, {ZN1, IDLE1, WAKE1, CNT1});
        end
        RN = 1'b1;
        E  = 1'b1;
    endtask

    task automatic test_idle_entry(input string tag);
        for (int e = 1; e <= 12; e++) begin
            logic [6:0] exp0, exp1;
            step();
            exp0 = {e >= 2, e >= 10, 1'b0, 4'(e >= 10 ? 8 : (e >= 3 ? e - 2 : 0))};
            exp1 = {e >= 2, e >= 3, 1'b0, 4'(e >= 3 ? 1 : 0)};
            n_checks++;
            if ({ZN, IDLE, WAKE, CNT} !== exp0) begin
                n_fail++;
                $display("FAIL %s edge %0d {ZN,IDLE,WAKE,CNT} got %b want %b", tag, e, {ZN, IDLE, WAKE, CNT}, exp0);
            end
            n_checks++;
            if ({ZN1, IDLE1, WAKE1, CNT1} !== exp1) begin
                n_fail++;
                $display("FAIL %s_ic1 edge %0d got %b want %b", tag, e, {ZN1, IDLE1, WAKE1, CNT1}, exp1);
            end
        end
    endtask

    task automatic test_wake();
        logic [6:0] exp0 [1:4];
        logic [6:0] exp1 [1:4];
        exp0[1] = {1'b1, 1'b1, 1'b0, 4'd8};
        exp0[2] = {1'b0, 1'b1, 1'b0, 4'd8};
        exp0[3] = {1'b1, 1'b0, 1'b1, 4'd0};
        exp0[4] = {1'b1, 1'b0, 1'b0, 4'd1};
        exp1[1] = {1'b1, 1'b1, 1'b0, 4'd1};
        exp1[2] = {1'b0, 1'b1, 1'b0, 4'd1};
        exp1[3] = {1'b1, 1'b0, 1'b1, 4'd0};
        exp1[4] = {1'b1, 1'b1, 1'b0, 4'd1};
        A3 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            A3 = 1'b0;
            n_checks++;
            if ({ZN, IDLE, WAKE, CNT} !== exp0[e]) begin
                n_fail++;
                $display("FAIL wake edge %0d got %b want %b", e, {ZN, IDLE, WAKE, CNT}, exp0[e]);
            end
            n_checks++;
            if ({ZN1, IDLE1, WAKE1, CNT1} !== exp1[e]) begin
                n_fail++;
                $display("FAIL wake_ic1 edge %0d got %b want %b", e, {ZN1, IDLE1, WAKE1, CNT1}, exp1[e]);
            end
        end
        for (int e = 5; e <= 11; e++) begin
            logic [6:0] exp;
            step();
            exp = {1'b1, e == 11, 1'b0, 4'(e - 3)};
            n_checks++;
            if ({ZN, IDLE, WAKE, CNT} !== exp) begin
                n_fail++;
                $display("FAIL wake_recount edge %0d got %b want %b", e, {ZN, IDLE, WAKE, CNT}, exp);
            end
        end
    endtask

    task automatic test_enable();
        E = 1'b0;
        step();
        n_checks++;
        if ({ZN, IDLE, WAKE, CNT, IDLE1, WAKE1, CNT1} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL enable_drop got %b/%b want 1000000/000000", {ZN, IDLE, WAKE, CNT}, {IDLE1, WAKE1, CNT1});
        end
        E = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            logic [6:0] exp;
            step();
            exp = {1'b1, e == 8, 1'b0, 4'(e)};
            n_checks++;
            if ({ZN, IDLE, WAKE, CNT} !== exp) begin
                n_fail++;
                $display("FAIL enable_recount edge %0d got %b want %b", e, {ZN, IDLE, WAKE, CNT}, exp);
            end
            n_checks++;
            if ({IDLE1, CNT1} !== 5'b1_0001) begin
                n_fail++;
                $display("FAIL enable_ic1 edge %0d {IDLE,CNT} got %b want 10001", e, {IDLE1, CNT1});
            end
        end
    endtask

    task automatic test_abort();
        E = 1'b0;
        step();
        E = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            logic [6:0] exp;
            if (e == 6) A2 = 1'b1;
            step();
            if (e == 6) A2 = 1'b0;
            exp = e <= 7 ? {e != 7, 1'b0, 1'b0, 4'(e)}
                : {1'b1, e == 16, 1'b0, 4'(e - 8)};
            n_checks++;
            if ({ZN, IDLE, WAKE, CNT} !== exp) begin
                n_fail++;
                $display("FAIL abort edge %0d got %b want %b", e, {ZN, IDLE, WAKE, CNT}, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        #2 RN = 1'b0;
        #1;
        n_checks++;
        if ({ZN, IDLE, WAKE, CNT, ZN1, IDLE1, WAKE1, CNT1} !== 14'b0) begin
            n_fail++;
            $display("FAIL async_reset got %b/%b want all zero", {ZN, IDLE, WAKE, CNT}, {ZN1, IDLE1, WAKE1, CNT1});
        end
        step();
        RN = 1'b1;
        test_idle_entry("post_reset");
    endtask

    task automatic test_back_to_back();
        logic pw = 1'b0, pw1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            A1 = ($urandom_range(3) == 0);
            A2 = ($urandom_range(7) == 0);
            A3 = ($urandom_range(7) == 0);
            A4 = ($urandom_range(7) == 0);
            step();
            n_checks++;
            if (WAKE1 && pw1) begin
                n_fail++;
                $display("FAIL b2b_wake_ic1 cycle %0d WAKE high twice, want single pulse", i);
            end
            n_checks++;
            if (CNT1 > 4'd1) begin
                n_fail++;
                $display("FAIL b2b_cnt_ic1 cycle %0d CNT got %0d want <= 1", i, CNT1);
            end
            n_checks++;
            if (WAKE && pw) begin
                n_fail++;
                $display("FAIL b2b_wake cycle %0d WAKE high twice, want single pulse", i);
            end
            n_checks++;
            if (CNT > 4'd8) begin
                n_fail++;
                $display("FAIL b2b_cnt cycle %0d CNT got %0d want <= 8", i, CNT);
            end
            pw  = WAKE;
            pw1 = WAKE1;
        end
        {A1, A2, A3, A4} = 4'b0;
    endtask

    initial begin
        test_reset();
        test_idle_entry("idle_entry");
        test_wake();
        test_enable();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
